// File: rtl/core_pkg.sv
// Shared integer-core types: physical/logical register indices and free-list pointer width.
// IPHYREG_NUM may be overridden on the command line; it defaults to 64.
`ifndef IPHYREG_NUM
`define IPHYREG_NUM 64
`endif

package core_pkg;

    localparam int ARCH_REG_NUM = 32;
    localparam int IPHYREG_NUM  = `IPHYREG_NUM;

    typedef logic [$clog2(IPHYREG_NUM)-1:0]              iprIdx_t;
    typedef logic [$clog2(ARCH_REG_NUM)-1:0]             ilrIdx_t;
    typedef logic [$clog2(IPHYREG_NUM-ARCH_REG_NUM):0]   freelist_ptr_t;

endpackage

// File: rtl/prefix_popcount.sv
// Per-bit exclusive prefix population count of an N-bit mask, plus the total count.
module prefix_popcount #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         mask,
    output logic [N-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    always_comb begin
        // NOTE: blocking assignments here are deliberate; total is a running sum read back within the same loop.
        total  = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = total;
            total     = total + CW'(mask[i]);
        end
    end

endmodule

// File: rtl/int_freelist.sv
// Integer physical-register free list: speculative/committed read pointers, compacted alloc and release.
// Optional checker (busy vector + sticky o_err) enabled by defining INT_FREELIST_CHECK_EN.
`ifndef IPHYREG_NUM
`define IPHYREG_NUM 64
`endif

module int_freelist
    import core_pkg::*;
#(
    parameter  int PHYREG_NUM   = `IPHYREG_NUM,
    parameter  int RENAME_WIDTH = 4,
    parameter  int COMMIT_WIDTH = 4,
    localparam int DEPTH        = PHYREG_NUM - ARCH_REG_NUM,
    localparam int PTR_W        = $clog2(DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [RENAME_WIDTH-1:0]          i_alloc_req,
    input  logic                             i_alloc_fire,
    output logic                             o_can_alloc,
    output iprIdx_t [RENAME_WIDTH-1:0]       o_alloc_prd,
    input  logic [COMMIT_WIDTH-1:0]          i_commit_alloc,
    input  logic [COMMIT_WIDTH-1:0]          i_commit_free,
    input  iprIdx_t [COMMIT_WIDTH-1:0]       i_commit_old_prd,
    input  logic                             i_squash,
    output logic [PTR_W-1:0]                 o_free_cnt
`ifdef INT_FREELIST_CHECK_EN
    ,
    output logic                             o_err
`endif
);

    localparam int IDX_W = PTR_W - 1;
    localparam int ACW   = $clog2(RENAME_WIDTH + 1);
    localparam int RCW   = $clog2(COMMIT_WIDTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    iprIdx_t             entry [DEPTH];
    ptr_t                spec_rptr, cmt_rptr, wptr;
    ptr_t                spec_rptr_next, cmt_rptr_next, wptr_next;
    ptr_t                cmt_cnt;
    logic                full, rel_en, alloc_go;
    logic [IDX_W-1:0]    wr_idx [COMMIT_WIDTH];

    logic [RENAME_WIDTH-1:0][ACW-1:0] alloc_pre;
    logic [ACW-1:0]                   alloc_total;
    logic [COMMIT_WIDTH-1:0][RCW-1:0] rel_pre;
    logic [RCW-1:0]                   rel_total;

    prefix_popcount #(.N(RENAME_WIDTH)) u_alloc_pc (
        .mask   (i_alloc_req),
        .prefix (alloc_pre),
        .total  (alloc_total)
    );

    prefix_popcount #(.N(COMMIT_WIDTH)) u_rel_pc (
        .mask   (i_commit_free),
        .prefix (rel_pre),
        .total  (rel_total)
    );

    assign o_free_cnt  = wptr - spec_rptr;
    assign o_can_alloc = (o_free_cnt >= PTR_W'(RENAME_WIDTH));
    assign full        = ((wptr - cmt_rptr) == ptr_t'(DEPTH));
    assign rel_en      = ~full;
    assign alloc_go    = i_alloc_fire & o_can_alloc & ~i_squash;

    always_comb begin
        o_alloc_prd = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            if (i_alloc_req[k])
                o_alloc_prd[k] = entry[IDX_W'(spec_rptr + ptr_t'(alloc_pre[k]))];
        end
    end

    always_comb begin
        cmt_cnt = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++)
            cmt_cnt = cmt_cnt + ptr_t'(i_commit_alloc[k]);
        for (int k = 0; k < COMMIT_WIDTH; k++)
            wr_idx[k] = IDX_W'(wptr + ptr_t'(rel_pre[k]));
    end

    // A squash rewinds to the committed pointer including this cycle's commits.
    assign cmt_rptr_next  = cmt_rptr + cmt_cnt;
    assign spec_rptr_next = i_squash ? cmt_rptr_next :
                            alloc_go ? spec_rptr + ptr_t'(alloc_total) : spec_rptr;
    assign wptr_next      = rel_en ? wptr + ptr_t'(rel_total) : wptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is reset on purpose; its initial contents (32+i) are the architectural free pool.
            for (int i = 0; i < DEPTH; i++)
                entry[i] <= iprIdx_t'(ARCH_REG_NUM + i);
            spec_rptr <= '0;
            cmt_rptr  <= '0;
            wptr      <= ptr_t'(DEPTH);
        end else begin
            spec_rptr <= spec_rptr_next;
            cmt_rptr  <= cmt_rptr_next;
            wptr      <= wptr_next;
            if (rel_en) begin
                for (int k = 0; k < COMMIT_WIDTH; k++) begin
                    if (i_commit_free[k])
                        entry[wr_idx[k]] <= i_commit_old_prd[k];
                end
            end
        end
    end

`ifdef INT_FREELIST_CHECK_EN
    logic [PHYREG_NUM-1:0] busy, busy_next;
    logic                  err_now;

    always_comb begin
        busy_next = busy;
        err_now   = i_alloc_fire & ~o_can_alloc;
        if (i_squash) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ptr_t'(i) < ptr_t'(spec_rptr - cmt_rptr_next))
                    busy_next[entry[IDX_W'(cmt_rptr_next + ptr_t'(i))]] = 1'b0;
            end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (i_commit_free[k]) begin
                if (full || (i_commit_old_prd[k] == '0) || !busy[i_commit_old_prd[k]])
                    err_now = 1'b1;
                if (rel_en)
                    busy_next[i_commit_old_prd[k]] = 1'b0;
            end
        end
        if (alloc_go) begin
            for (int k = 0; k < RENAME_WIDTH; k++) begin
                if (i_alloc_req[k]) begin
                    if (busy[o_alloc_prd[k]])
                        err_now = 1'b1;
                    busy_next[o_alloc_prd[k]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= {{(PHYREG_NUM-ARCH_REG_NUM){1'b0}}, {ARCH_REG_NUM{1'b1}}};
            o_err <= 1'b0;
        end else begin
            busy  <= busy_next;
            o_err <= o_err | err_now;
            assert (!err_now) else $error("int_freelist: illegal allocation or release");
        end
    end
`endif

endmodule

// File: tb/tb_int_freelist.sv
// Self-checking bench for int_freelist: directed scenarios plus randomized traffic against a queue model.
module tb_int_freelist;
    import core_pkg::*;

    localparam int RW    = 4;
    localparam int CW    = 4;
    localparam int DEPTH = 32;

    logic               clk;
    logic               rst;
    logic [RW-1:0]      alloc_req;
    logic               alloc_fire;
    logic               can_alloc;
    iprIdx_t [RW-1:0]   alloc_prd;
    logic [CW-1:0]      commit_alloc;
    logic [CW-1:0]      commit_free;
    iprIdx_t [CW-1:0]   old_prd;
    logic               squash;
    logic [5:0]         free_cnt;
`ifdef INT_FREELIST_CHECK_EN
    logic               err;
`endif

    int_freelist #(.PHYREG_NUM(64), .RENAME_WIDTH(RW), .COMMIT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_alloc_req      (alloc_req),
        .i_alloc_fire     (alloc_fire),
        .o_can_alloc      (can_alloc),
        .o_alloc_prd      (alloc_prd),
        .i_commit_alloc   (commit_alloc),
        .i_commit_free    (commit_free),
        .i_commit_old_prd (old_prd),
        .i_squash         (squash),
        .o_free_cnt       (free_cnt)
`ifdef INT_FREELIST_CHECK_EN
        ,
        .o_err            (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: free_q = allocatable regs in order, inflight_q = speculatively allocated,
    // owned_q = regs held by the architecture that the bench may later release.
    int free_q[$];
    int inflight_q[$];
    int owned_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        inflight_q.delete();
        owned_q.delete();
        for (int i = 0; i < DEPTH; i++) free_q.push_back(32 + i);
        for (int i = 1; i < 32; i++) owned_q.push_back(i);
        exp_err = 1'b0;
    endtask

    task automatic take_owned(input int v);
        for (int i = 0; i < owned_q.size(); i++) begin
            if (owned_q[i] == v) begin
                owned_q.delete(i);
                break;
            end
        end
    endtask

    task automatic check_outputs();
        int n;
        check("free_cnt", 32'(free_cnt), 32'(free_q.size()));
        check("can_alloc", 32'(can_alloc), 32'(free_q.size() >= RW));
        n = 0;
        for (int k = 0; k < RW; k++) begin
            if (alloc_req[k]) begin
                if (n < free_q.size())
                    check($sformatf("alloc_prd[%0d]", k), 32'(alloc_prd[k]), 32'(free_q[n]));
                n++;
            end else begin
                check($sformatf("idle_prd[%0d]", k), 32'(alloc_prd[k]), 32'd0);
            end
        end
`ifdef INT_FREELIST_CHECK_EN
        check("err", 32'(err), 32'(exp_err));
`endif
    endtask

    task automatic model_update();
        bit full;
        full = (free_q.size() + inflight_q.size()) == DEPTH;
        if (alloc_fire && free_q.size() >= RW && !squash)
            for (int k = 0; k < RW; k++)
                if (alloc_req[k]) inflight_q.push_back(free_q.pop_front());
        for (int k = 0; k < CW; k++)
            if (commit_alloc[k]) owned_q.push_back(inflight_q.pop_front());
        if (squash)
            while (inflight_q.size() > 0) free_q.push_front(inflight_q.pop_back());
        for (int k = 0; k < CW; k++) begin
            if (commit_free[k]) begin
                if (full) owned_q.push_back(int'(old_prd[k]));
                else      free_q.push_back(int'(old_prd[k]));
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs are checked 1ns later, then the model steps at the rising edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        alloc_req    = '0;
        alloc_fire   = 1'b0;
        commit_alloc = '0;
        commit_free  = '0;
        old_prd      = '0;
        squash       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        check("rst_free_cnt", 32'(free_cnt), 32'd32);
        check("rst_can_alloc", 32'(can_alloc), 32'd1);
`ifdef INT_FREELIST_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int lim, cnt, room, idx;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);

        // Reset contents and draining the list four at a time.
        do_reset();
        alloc_req = 4'b1111;
        #1;
        for (int k = 0; k < RW; k++)
            check($sformatf("rst_prd[%0d]", k), 32'(alloc_prd[k]), 32'(32 + k));
        alloc_fire = 1'b1;
        repeat (7) step();
        #1;
        check("seven_free_cnt", 32'(free_cnt), 32'd4);
        check("seven_prd0", 32'(alloc_prd[0]), 32'd60);
        check("seven_prd3", 32'(alloc_prd[3]), 32'd63);
        step();
`ifdef INT_FREELIST_CHECK_EN
        alloc_fire = 1'b0;
`endif
        #1;
        check("empty_free_cnt", 32'(free_cnt), 32'd0);
        check("empty_can_alloc", 32'(can_alloc), 32'd0);
        step();
        alloc_fire = 1'b0;
        #1;
        check("ignored_fire_cnt", 32'(free_cnt), 32'd0);

        // Sparse request mask is compacted.
        do_reset();
        alloc_req  = 4'b1010;
        alloc_fire = 1'b1;
        #1;
        check("sparse_prd1", 32'(alloc_prd[1]), 32'd32);
        check("sparse_prd3", 32'(alloc_prd[3]), 32'd33);
        step();
        alloc_fire = 1'b0;
        alloc_req  = 4'b0001;
        #1;
        check("sparse_free_cnt", 32'(free_cnt), 32'd30);
        check("sparse_next_prd0", 32'(alloc_prd[0]), 32'd34);
        step();

        // Squash together with a two-slot commit.
        do_reset();
        alloc_req  = 4'b1111;
        alloc_fire = 1'b1;
        repeat (2) step();
        alloc_fire   = 1'b0;
        alloc_req    = '0;
        commit_alloc = 4'b0011;
        squash       = 1'b1;
        step();
        commit_alloc = '0;
        squash       = 1'b0;
        alloc_req    = 4'b0001;
        #1;
        check("squash_free_cnt", 32'(free_cnt), 32'd30);
        check("squash_prd0", 32'(alloc_prd[0]), 32'd34);
        step();

        // Release from empty becomes visible only the next cycle.
        do_reset();
        alloc_req  = 4'b1111;
        alloc_fire = 1'b1;
        repeat (8) step();
        alloc_fire   = 1'b0;
        alloc_req    = '0;
        commit_alloc = 4'b1111;
        repeat (8) step();
        commit_alloc = '0;
        take_owned(5);
        take_owned(9);
        commit_free = 4'b0101;
        old_prd[0]  = iprIdx_t'(5);
        old_prd[1]  = iprIdx_t'(17);
        old_prd[2]  = iprIdx_t'(9);
        old_prd[3]  = iprIdx_t'(21);
        #1;
        check("rel_same_cycle_can_alloc", 32'(can_alloc), 32'd0);
        step();
        commit_free = '0;
        alloc_req   = 4'b0011;
        #1;
        check("rel_free_cnt", 32'(free_cnt), 32'd2);
        check("rel_prd0", 32'(alloc_prd[0]), 32'd5);
        check("rel_prd1", 32'(alloc_prd[1]), 32'd9);
        step();

`ifndef INT_FREELIST_CHECK_EN
        // Release while full is dropped.
        do_reset();
        take_owned(7);
        commit_free = 4'b0001;
        old_prd[0]  = iprIdx_t'(7);
        step();
        commit_free = '0;
        alloc_req   = 4'b1111;
        #1;
        check("drop_free_cnt", 32'(free_cnt), 32'd32);
        check("drop_prd0", 32'(alloc_prd[0]), 32'd32);
        step();
`else
        // Releasing a register that is already free raises a sticky error.
        do_reset();
        commit_free = 4'b0001;
        old_prd[0]  = iprIdx_t'(40);
        step();
        commit_free = '0;
        exp_err     = 1'b1;
        #1;
        check("err_set", 32'(err), 32'd1);
        repeat (3) step();
        check("err_sticky", 32'(err), 32'd1);
`endif

        // Randomized legal traffic with one mid-run reset.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc == 700) do_reset();
            alloc_req  = RW'($urandom);
            alloc_fire = (free_q.size() >= RW) && ($urandom_range(0, 3) != 0);
            squash     = ($urandom_range(0, 15) == 0);
            lim = inflight_q.size();
            cnt = 0;
            commit_alloc = '0;
            for (int k = 0; k < CW; k++) begin
                if (cnt < lim && $urandom_range(0, 1) == 1) begin
                    commit_alloc[k] = 1'b1;
                    cnt++;
                end
            end
            room = DEPTH - free_q.size() - inflight_q.size();
            commit_free = '0;
            for (int k = 0; k < CW; k++) begin
                old_prd[k] = iprIdx_t'($urandom);
                if (room > 0 && owned_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    idx = $urandom_range(0, owned_q.size() - 1);
                    old_prd[k] = iprIdx_t'(owned_q[idx]);
                    owned_q.delete(idx);
                    commit_free[k] = 1'b1;
                    room--;
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
